// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with hold limit; registered grants, bus mux combinational from state.
// Grant follows a request by one edge; a dropped request reaches m_req in the same cycle, grant drops at the next edge.
module bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m0_dout,
  input  logic [63:0] m1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [63:0] m0_din,
  output logic [63:0] m1_din,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic [63:0] m_din
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req && !m1_req)      state_d = GRANT0;
        else if (m1_req && !m0_req) state_d = GRANT1;
        else if (m0_req && m1_req)  state_d = last_q ? GRANT0 : GRANT1;
      end
      GRANT0: begin
        if (!m0_req)                              state_d = m1_req ? GRANT1 : IDLE;
        else if (m1_req && hold_cnt_q == HOLD_LAST) state_d = GRANT1;
      end
      GRANT1: begin
        if (!m1_req)                              state_d = m0_req ? GRANT0 : IDLE;
        else if (m0_req && hold_cnt_q == HOLD_LAST) state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase
  end

  // last tracks the master most recently entered, used only for IDLE ties
  always_comb begin
    last_d = last_q;
    if (state_d == GRANT0 && state_q != GRANT0) last_d = 1'b0;
    if (state_d == GRANT1 && state_q != GRANT1) last_d = 1'b1;
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d != state_q || state_d == IDLE) hold_cnt_d = 8'd0;
    else if (hold_cnt_q != 8'hFF)              hold_cnt_d = hold_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign m0_grant = (state_q == GRANT0);
  assign m1_grant = (state_q == GRANT1);

  always_comb begin
    m_req  = 1'b0;
    m_wr   = 1'b0;
    m_addr = 16'h0;
    m_dout = 64'h0;
    if (m0_grant) begin
      m_req  = m0_req;
      m_wr   = m0_wr;
      m_addr = m0_addr;
      m_dout = m0_dout;
    end else if (m1_grant) begin
      m_req  = m1_req;
      m_wr   = m1_wr;
      m_addr = m1_addr;
      m_dout = m1_dout;
    end
  end

  assign m0_din = m0_grant ? m_din : 64'h0;
  assign m1_din = m1_grant ? m_din : 64'h0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with MAX_HOLD=4.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m1_req, m0_wr, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [63:0] m0_dout, m1_dout;
  logic        m0_grant, m1_grant;
  logic [63:0] m0_din, m1_din;
  logic        m_req, m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_dout;
  logic [63:0] m_din;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .m0_din(m0_din), .m1_din(m1_din),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_din(m_din)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    m0_wr = 1'b1;  m1_wr = 1'b1;
    m0_addr = 16'h0010; m1_addr = 16'h7000;
    m0_dout = 64'hAAAA_0000_0000_0001; m1_dout = 64'hBBBB_0000_0000_0002;
    m_din = 64'hDEAD_BEEF_CAFE_F00D;

    // reset with requests already high: everything must read 0
    tick(); tick();
    chk("rst_g0", 64'(m0_grant), 64'd0);
    chk("rst_g1", 64'(m1_grant), 64'd0);
    chk("rst_mreq", 64'(m_req), 64'd0);
    chk("rst_mwr", 64'(m_wr), 64'd0);
    chk("rst_maddr", 64'(m_addr), 64'd0);
    chk("rst_mdout", m_dout, 64'd0);
    chk("rst_m0din", m0_din, 64'd0);
    chk("rst_m1din", m1_din, 64'd0);

    // first tie after reset goes to M0
    reset_n = 1'b1;
    tick();
    chk("tie_g0", 64'(m0_grant), 64'd1);
    chk("tie_g1", 64'(m1_grant), 64'd0);
    chk("tie_maddr", 64'(m_addr), 64'h0010);
    chk("tie_mreq", 64'(m_req), 64'd1);

    // continuous contention: 4 cycles each, no gaps
    for (int k = 1; k < 20; k++) begin
      tick();
      chk("rr_g0", 64'(m0_grant), ((k / 4) % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_g1", 64'(m1_grant), ((k / 4) % 2 == 1) ? 64'd1 : 64'd0);
    end

    // M0 alone: write then read back
    m1_req = 1'b0;
    m0_wr = 1'b1; m0_addr = 16'h0010; m0_dout = 64'h1122334455667788;
    m_din = 64'h0;
    tick();
    chk("wr_g0", 64'(m0_grant), 64'd1);
    chk("wr_mwr", 64'(m_wr), 64'd1);
    chk("wr_maddr", 64'(m_addr), 64'h0010);
    chk("wr_mdout", m_dout, 64'h1122334455667788);
    chk("wr_m1din", m1_din, 64'd0);
    m0_wr = 1'b0; m_din = 64'h1122334455667788;
    tick();
    chk("rd_mwr", 64'(m_wr), 64'd0);
    chk("rd_m0din", m0_din, 64'h1122334455667788);
    chk("rd_m1din", m1_din, 64'd0);

    // release: m_req drops immediately, grant one edge later
    m0_req = 1'b0;
    #1;
    chk("rel_mreq_now", 64'(m_req), 64'd0);
    chk("rel_g0_still", 64'(m0_grant), 64'd1);
    tick();
    chk("rel_g0", 64'(m0_grant), 64'd0);
    chk("rel_maddr", 64'(m_addr), 64'd0);
    chk("rel_m0din", m0_din, 64'd0);

    // M1 reads 0x7008, then hands over directly to M0
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h7008; m_din = 64'h0000_0000_0000_7008;
    tick();
    chk("m1_g1", 64'(m1_grant), 64'd1);
    chk("m1_maddr", 64'(m_addr), 64'h7008);
    chk("m1_din", m1_din, 64'h0000_0000_0000_7008);
    chk("m1_m0din", m0_din, 64'd0);
    m1_req = 1'b0; m0_req = 1'b1;
    #1;
    chk("ho_mreq_now", 64'(m_req), 64'd0);
    tick();
    chk("ho_g0", 64'(m0_grant), 64'd1);
    chk("ho_g1", 64'(m1_grant), 64'd0);

    // reset during a GRANT1 burst
    m0_req = 1'b0; m1_req = 1'b1;
    tick();
    chk("burst_g1", 64'(m1_grant), 64'd1);
    tick();
    reset_n = 1'b0;
    tick();
    chk("mrst_g1", 64'(m1_grant), 64'd0);
    chk("mrst_g0", 64'(m0_grant), 64'd0);
    chk("mrst_mreq", 64'(m_req), 64'd0);
    chk("mrst_maddr", 64'(m_addr), 64'd0);
    reset_n = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("mrst_tie_g0", 64'(m0_grant), 64'd1);

    // fresh hold count after reset: M0 keeps exactly 4 cycles
    tick(); tick(); tick();
    chk("hold4_g0", 64'(m0_grant), 64'd1);
    tick();
    chk("hold4_g1", 64'(m1_grant), 64'd1);

    // unmapped address passes through, bus returns 0
    m1_req = 1'b0; m1_addr = 16'h0900; m_din = 64'h0;
    tick();
    chk("unm_g0", 64'(m0_grant), 64'd1);
    m0_addr = 16'h0900;
    #1;
    chk("unm_maddr", 64'(m_addr), 64'h0900);
    chk("unm_m0din", m0_din, 64'd0);

    // IDLE tie after serving M0 goes to M1
    m0_req = 1'b0;
    tick();
    chk("idle_g0", 64'(m0_grant), 64'd0);
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    chk("tie2_g1", 64'(m1_grant), 64'd1);
    chk("tie2_g0", 64'(m0_grant), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // grants must never both be high
  always @(negedge clk) begin
    if (m0_grant && m1_grant) begin
      n_cmp++;
      n_err++;
      $error("FAIL onehot: observed both grants high expected at most one");
    end
  end

endmodule
